// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: 8N1 UART receiver on an oversampled baud tick, LSB first.
// Define UART_RX_PARITY_EN to expect one even-parity bit between data and stop.
module uart_rx_deserializer #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 19200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int TICK_DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_rx_data,
  output logic       os_rx_done,
  output logic       os_frame_err,
  output logic       os_parity_err,
  output logic       os_busy
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif
  state_t        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [SW-1:0] s_q, s_d;
  logic [3:0]    n_q, n_d;
  logic [7:0]    shift_q, shift_d, data_q, data_d;
  logic          rx_m_q, rx_s_q, done_q, done_d, ferr_q, ferr_d;
  logic          tick, bit_end;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d, perr_q, perr_d;
`endif

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rx_m_q  <= i_rx;
      rx_s_q  <= rx_m_q;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end

  always_comb begin
    tick    = tcnt_q == TW'(TICK_DIV - 1);
    tcnt_d  = tick ? '0 : tcnt_q + 1'b1;
    bit_end = tick && s_q == SW'(OVERSAMPLE - 1);
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: if (!rx_s_q) begin
        state_d = START;
        s_d     = '0;
      end
      // The first tick after the edge covers only a partial period, so one
      // extra tick is spent here to keep every sample on or after mid-bit.
      START: if (tick) begin
        s_d = s_q + 1'b1;
        if (s_q == SW'(OVERSAMPLE / 2)) begin
          state_d = rx_s_q ? IDLE : DATA;
          s_d     = '0;
          n_d     = '0;
          shift_d = '0;
`ifdef UART_RX_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      DATA: if (tick) begin
        s_d = bit_end ? '0 : s_q + 1'b1;
        if (bit_end) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          n_d     = n_q + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (n_q == 4'(DATA_BITS - 1)) state_d = PARITY;
`else
          if (n_q == 4'(DATA_BITS - 1)) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        s_d = bit_end ? '0 : s_q + 1'b1;
        if (bit_end) begin
          par_d   = rx_s_q ^ (^shift_q);
          state_d = STOP;
        end
      end
`endif
      STOP: if (tick) begin
        s_d = bit_end ? '0 : s_q + 1'b1;
        if (bit_end) begin
          state_d = rx_s_q ? IDLE : WAIT_HIGH;
          ferr_d  = !rx_s_q;
`ifdef UART_RX_PARITY_EN
          perr_d  = rx_s_q && par_q;
          done_d  = rx_s_q && !par_q;
          data_d  = (rx_s_q && !par_q) ? shift_q >> (8 - DATA_BITS) : data_q;
`else
          done_d  = rx_s_q;
          data_d  = rx_s_q ? shift_q >> (8 - DATA_BITS) : data_q;
`endif
        end
      end
      WAIT_HIGH: if (rx_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_rx_data    = data_q;
  assign os_rx_done   = done_q;
  assign os_frame_err = ferr_q;
  assign os_busy      = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
  assign os_parity_err = perr_q;
`else
  assign os_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: frame-level scoreboard bench for uart_rx_deserializer.
// Expected events are derived from the bits each frame puts on the line.
module tb_uart_rx_deserializer;
  localparam int BIT = 160;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  typedef struct {int kind; logic [7:0] val; int lo; int hi;} ev_t;

  logic       clk = 1'b0, rst = 1'b0, i_rx = 1'b1;
  logic [7:0] o_rx_data;
  logic       os_rx_done, os_frame_err, os_parity_err, os_busy;
  int         cyc = 0, n_chk = 0, n_fail = 0;
  int         n_done = 0, n_ferr = 0, n_perr = 0, last_done = 0, prev_done = 0;
  logic [7:0] exp_data = 8'h00, prev_val = 8'h00;
  ev_t        q[$];

  uart_rx_deserializer #(.CLK_FREQ(1600000), .BAUD_RATE(10000)) dut (
    .clk(clk), .rst(rst), .i_rx(i_rx), .o_rx_data(o_rx_data), .os_rx_done(os_rx_done),
    .os_frame_err(os_frame_err), .os_parity_err(os_parity_err), .os_busy(os_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame on the line; the scoreboard entry says what the receiver must report.
  task automatic send(input logic [7:0] d, input logic par, input logic stop, input int hold);
    ev_t e;
    e.kind = !stop ? 1 : (PAR_EN && par != ^d) ? 2 : 0;
    e.val  = d;
    e.lo   = cyc + 1522;
    e.hi   = cyc + 1535;
    q.push_back(e);
    i_rx = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 8; i++) begin
      i_rx = d[i];
      wait_clk(BIT);
    end
    if (PAR_EN) begin
      i_rx = par;
      wait_clk(BIT);
    end
    i_rx = stop;
    wait_clk(BIT);
    if (!stop) begin
      if (hold > 0) wait_clk(hold);
      i_rx = 1'b1;
    end
  endtask

  initial forever begin
    ev_t e;
    int k;
    bit  was_good;
    @(negedge clk);
    if (!rst) begin
      exp_data = 8'h00;
      q.delete();
      was_good = 1'b0;
      chk("reset_outputs", int'({o_rx_data, os_rx_done, os_frame_err, os_parity_err, os_busy}), 0);
    end else begin
      if (was_good) chk("busy_after_pulse", int'(os_busy), 0);
      was_good = os_rx_done | os_parity_err;
      if (os_rx_done | os_frame_err | os_parity_err) begin
        k = os_rx_done ? 0 : os_frame_err ? 1 : 2;
        n_done += int'(os_rx_done);
        n_ferr += int'(os_frame_err);
        n_perr += int'(os_parity_err);
        chk("one_pulse_at_a_time", int'(os_rx_done) + int'(os_frame_err) + int'(os_parity_err), 1);
        chk("pulse_expected", int'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("pulse_kind", k, e.kind);
          chk_rng("pulse_cycle", cyc, e.lo, e.hi);
          if (k == 0 && e.kind == 0) begin
            prev_val  = exp_data;
            exp_data  = e.val;
            prev_done = last_done;
            last_done = cyc;
          end
        end
      end else if (q.size() != 0 && cyc > q[0].hi) begin
        chk("pulse_missing_kind", -1, q[0].kind);
        void'(q.pop_front());
      end
      chk("rx_data", int'(o_rx_data), int'(exp_data));
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, f0, p0, r, gap;
    logic [7:0] d;
    logic p;
    wait_clk(5);
    rst = 1'b1;
    wait_clk(20);
    send(8'h01, 1'b1, 1'b1, 0);
    chk("first_byte", int'(o_rx_data), 8'h01);
    d0 = n_done;
    f0 = n_ferr;
    i_rx = 1'b0;
    wait_clk(40);
    i_rx = 1'b1;
    for (int i = 0; i < 100 && os_busy; i++) wait_clk(1);
    chk("glitch_busy_clear", int'(os_busy), 0);
    wait_clk(100);
    chk("glitch_no_done", n_done - d0, 0);
    send(8'h55, 1'b0, 1'b0, 2000);
    chk("break_one_frame_err", n_ferr - f0, 1);
    chk("break_no_done", n_done - d0, 0);
    chk("break_data_kept", int'(o_rx_data), 8'h01);
    wait_clk(10);
    send(8'h03, 1'b0, 1'b1, 0);
    chk("after_break_byte", int'(o_rx_data), 8'h03);
    wait_clk(37);
    send(8'h02, 1'b1, 1'b1, 0);
    send(8'h03, 1'b0, 1'b1, 0);
    chk_rng("b2b_spacing", last_done - prev_done, 1590, 1610);
    chk("b2b_first", int'(prev_val), 8'h02);
    chk("b2b_second", int'(o_rx_data), 8'h03);
    wait_clk(13);
    i_rx = 1'b0;
    wait_clk(5 * BIT + 80);
    rst = 1'b0;
    #2;
    chk("async_reset_data", int'(o_rx_data), 0);
    chk("async_reset_flags", int'({os_rx_done, os_frame_err, os_parity_err, os_busy}), 0);
    i_rx = 1'b1;
    wait_clk(5);
    rst = 1'b1;
    wait_clk(20);
    d0 = n_done;
    send(8'hA5, 1'b0, 1'b1, 0);
    chk("post_reset_byte", int'(o_rx_data), 8'hA5);
    chk("post_reset_one_done", n_done - d0, 1);
    if (PAR_EN) begin
      p0 = n_perr;
      send(8'h07, 1'b1, 1'b1, 0);
      chk("parity_good_byte", int'(o_rx_data), 8'h07);
      d0 = n_done;
      send(8'h07, 1'b0, 1'b1, 0);
      chk("parity_bad_pulse", n_perr - p0, 1);
      chk("parity_bad_no_done", n_done - d0, 0);
      chk("parity_bad_data_kept", int'(o_rx_data), 8'h07);
    end
    for (int it = 0; it < 25; it++) begin
      r = $urandom_range(0, 9);
      gap = $urandom_range(0, 9);
      if (gap > 0) wait_clk(gap);
      if (r == 0) begin
        i_rx = 1'b0;
        wait_clk($urandom_range(1, 60));
        i_rx = 1'b1;
        wait_clk(150);
      end else begin
        d = 8'($urandom);
        p = ^d;
        if (PAR_EN && r == 2) p = ~p;
        send(d, p, r != 1, r == 1 ? $urandom_range(0, 400) : 0);
        if (r == 1) wait_clk(5);
      end
    end
    wait_clk(BIT);
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
